// File: rtl/writeback_regfile_pkg.sv
// Shared types and constants for the writeback / architectural-state stage.
package writeback_regfile_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wb_state_t;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam word_t    PC_STEP  = 32'h4;
    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/writeback_regfile_if.sv
// Exec-to-writeback result bus, register read ports and architectural status.
interface writeback_regfile_if;
    import writeback_regfile_pkg::*;

    logic     wb_valid;
    reg_idx_t wb_rd;
    logic     wb_rd_we;
    word_t    wb_rd_value;
    logic     wb_redirect;
    word_t    wb_next_pc;
    logic     stall;
    reg_idx_t rs1_addr;
    reg_idx_t rs2_addr;
    word_t    rs1_data;
    word_t    rs2_data;
    word_t    pc_reg;
    logic     flush;
    logic     misaligned;
    word_t    instret;

    modport master (
        output wb_valid, wb_rd, wb_rd_we, wb_rd_value, wb_redirect, wb_next_pc,
        output stall, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, pc_reg, flush, misaligned, instret
    );

    modport slave (
        input  wb_valid, wb_rd, wb_rd_we, wb_rd_value, wb_redirect, wb_next_pc,
        input  stall, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, pc_reg, flush, misaligned, instret
    );

endinterface

// File: rtl/writeback_regfile_regfile_2r1w.sv
// 32x32 register file: one write port, two combinational read ports, x0 hardwired.
// Optional write-through bypass when WB_FORWARD_BYPASS_EN is defined.
module regfile_2r1w
    import writeback_regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     we,
    input  reg_idx_t waddr,
    input  word_t    wdata,
    input  reg_idx_t raddr1,
    input  reg_idx_t raddr2,
    output word_t    rdata1,
    output word_t    rdata2
);

    word_t mem_reg [32];
    word_t stored1;
    word_t stored2;

    // Every entry needs a reset value, so storage is plain flops rather than RAM.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (we && (waddr == reg_idx_t'(gi)) && (waddr != REG_ZERO)) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign stored1 = (raddr1 == REG_ZERO) ? '0 : mem_reg[raddr1];
    assign stored2 = (raddr2 == REG_ZERO) ? '0 : mem_reg[raddr2];

`ifdef WB_FORWARD_BYPASS_EN
    assign rdata1 = (we && (waddr == raddr1) && (raddr1 != REG_ZERO)) ? wdata : stored1;
    assign rdata2 = (we && (waddr == raddr2) && (raddr2 != REG_ZERO)) ? wdata : stored2;
`else
    assign rdata1 = stored1;
    assign rdata2 = stored2;
`endif

endmodule

// File: rtl/writeback_regfile.sv
// RV32I writeback stage: commits exec results, owns the fetch PC and squashes
// wrong-path instructions after a redirect. Optional bypass: WB_FORWARD_BYPASS_EN.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter word_t RESET_PC     = 32'h0000_0000,
    parameter int    FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    writeback_regfile_if.slave   bus
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    wb_state_t  state_reg;
    wb_state_t  state_next;
    logic [2:0] cnt_reg;
    logic [2:0] cnt_next;
    word_t      pc_value_reg;
    word_t      pc_value_next;
    logic       misaligned_reg;
    word_t      instret_reg;

    logic commit;
    logic take_redirect;
    logic rf_we;
    logic unused_next_pc_lsb;

    assign unused_next_pc_lsb = bus.wb_next_pc[0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; the squash counter only moves on non-stalled cycles.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RUN: begin
                if (take_redirect) begin
                    state_next = FLUSH;
                    cnt_next   = FLUSH_INIT;
                end
            end
            FLUSH: begin
                if (!bus.stall) begin
                    if (cnt_reg == 3'd0) begin
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt_reg - 3'd1;
                    end
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Output logic
    always_comb begin
        commit        = (state_reg == RUN) && bus.wb_valid;
        take_redirect = commit && bus.wb_redirect;
        rf_we         = commit && bus.wb_rd_we && (bus.wb_rd != REG_ZERO);
        bus.flush     = (state_reg == FLUSH);
    end

    // A redirect overrides stall; otherwise stall only freezes sequential fetch.
    always_comb begin
        pc_value_next = pc_value_reg;
        if (take_redirect) begin
            pc_value_next = {bus.wb_next_pc[31:1], 1'b0};
        end else if (!bus.stall) begin
            pc_value_next = pc_value_reg + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_value_reg   <= RESET_PC;
            misaligned_reg <= 1'b0;
            instret_reg    <= '0;
        end else begin
            pc_value_reg <= pc_value_next;
            if (take_redirect && bus.wb_next_pc[1]) begin
                misaligned_reg <= 1'b1;
            end
            if (commit) begin
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    assign bus.pc_reg     = pc_value_reg;
    assign bus.misaligned = misaligned_reg;
    assign bus.instret    = instret_reg;

    regfile_2r1w u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (rf_we),
        .waddr  (bus.wb_rd),
        .wdata  (bus.wb_rd_value),
        .raddr1 (bus.rs1_addr),
        .raddr2 (bus.rs2_addr),
        .rdata1 (bus.rs1_data),
        .rdata2 (bus.rs2_data)
    );

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, commit, redirect/flush, async reset, bypass.
module tb_writeback_regfile;
    import writeback_regfile_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    writeback_regfile_if bus ();

    writeback_regfile #(
        .RESET_PC     (32'h0000_0100),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                         input logic [31:0] val, input logic redir, input logic [31:0] npc);
        bus.wb_valid    = v;
        bus.wb_rd       = rd;
        bus.wb_rd_we    = we;
        bus.wb_rd_value = val;
        bus.wb_redirect = redir;
        bus.wb_next_pc  = npc;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n        = 1'b0;
        bus.stall    = 1'b0;
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset state
        #12;
        check("rst_pc", bus.pc_reg, 32'h100);
        check("rst_flush", {31'b0, bus.flush}, 32'h0);
        check("rst_instret", bus.instret, 32'h0);
        rst_n = 1'b1;

        // 1: three idle cycles
        step(); step(); step();
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd31;
        #1;
        check("idle_pc", bus.pc_reg, 32'h10C);
        check("idle_instret", bus.instret, 32'h0);
        check("idle_rs1", bus.rs1_data, 32'h0);
        check("idle_rs2", bus.rs2_data, 32'h0);

        // 2: commit x5, then a write to x0
        drive(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        step();
        drive(1'b1, 5'd0, 1'b1, 32'h0000_1234, 1'b0, 32'h0);
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd5;
        #1;
        check("x0_during_write", bus.rs1_data, 32'h0);
        check("x5_committed", bus.rs2_data, 32'hDEADBEEF);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("x0_after_write", bus.rs1_data, 32'h0);
        check("instret_2", bus.instret, 32'h2);
        check("pc_114", bus.pc_reg, 32'h114);

        // 3: redirect with link write to misaligned target
        drive(1'b1, 5'd1, 1'b1, 32'h44, 1'b1, 32'h203);
        step();
        bus.rs1_addr = 5'd1;
        bus.rs2_addr = 5'd2;
        drive(1'b1, 5'd2, 1'b1, 32'h99, 1'b0, 32'h0);
        #1;
        check("redir_pc", bus.pc_reg, 32'h202);
        check("redir_x1", bus.rs1_data, 32'h44);
        check("redir_mis", {31'b0, bus.misaligned}, 32'h1);
        check("flush_c1", {31'b0, bus.flush}, 32'h1);
        check("instret_3", bus.instret, 32'h3);
        check("x2_no_bypass_sq", bus.rs2_data, 32'h0);
        step();
        // 4: redirect during FLUSH is ignored
        drive(1'b1, 5'd2, 1'b1, 32'h77, 1'b1, 32'h400);
        #1;
        check("flush_c2", {31'b0, bus.flush}, 32'h1);
        check("flush_pc_206", bus.pc_reg, 32'h206);
        check("x2_squashed_1", bus.rs2_data, 32'h0);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("flush_done", {31'b0, bus.flush}, 32'h0);
        check("pc_20A", bus.pc_reg, 32'h20A);
        check("x2_squashed_2", bus.rs2_data, 32'h0);
        check("instret_still_3", bus.instret, 32'h3);

        // 5: stall holds PC and counter in FLUSH, then async reset mid-flush
        drive(1'b1, 5'd0, 1'b0, 32'h0, 1'b1, 32'h300);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.stall = 1'b1;
        #1;
        check("even_redir_pc", bus.pc_reg, 32'h300);
        step();
        check("stall_pc_hold", bus.pc_reg, 32'h300);
        check("stall_flush_hold", {31'b0, bus.flush}, 32'h1);
        #1;
        rst_n = 1'b0;
        bus.rs1_addr = 5'd5;
        #1;
        check("arst_flush", {31'b0, bus.flush}, 32'h0);
        check("arst_pc", bus.pc_reg, 32'h100);
        check("arst_mis", {31'b0, bus.misaligned}, 32'h0);
        check("arst_instret", bus.instret, 32'h0);
        check("arst_x5", bus.rs1_data, 32'h0);
        bus.stall = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_pc", bus.pc_reg, 32'h104);
        check("post_rst_run", {31'b0, bus.flush}, 32'h0);

        // Stall does not block a commit
        bus.stall = 1'b1;
        bus.rs1_addr = 5'd3;
        drive(1'b1, 5'd3, 1'b1, 32'h33, 1'b0, 32'h0);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("stall_commit_pc", bus.pc_reg, 32'h104);
        check("stall_commit_x3", bus.rs1_data, 32'h33);
        check("stall_commit_instret", bus.instret, 32'h1);

        // 6: same-cycle read of a committing write
        bus.stall = 1'b0;
        drive(1'b1, 5'd7, 1'b1, 32'h11, 1'b0, 32'h0);
        step();
        bus.rs2_addr = 5'd7;
        drive(1'b1, 5'd7, 1'b1, 32'h55, 1'b0, 32'h0);
        #1;
`ifdef WB_FORWARD_BYPASS_EN
        check("bypass_same_cycle", bus.rs2_data, 32'h55);
`else
        check("no_bypass_same_cycle", bus.rs2_data, 32'h11);
`endif
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("x7_next_cycle", bus.rs2_data, 32'h55);
        check("instret_final", bus.instret, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Writeback and architectural-state stage of the RV32I pipeline, at the receiving end of the exec-to-writeback path.
- Consumes exec results (rd, rd value, next PC, jump/branch redirect) and commits them to the 32x32 general register file and the fetch PC.
- Serves rs1/rs2 read ports back to decode/exec, and squashes wrong-path instructions after a redirect through a flush state machine.
- Reports retired-instruction count and a misaligned-target flag.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC value loaded on reset.
- FLUSH_CYCLES, 2, number of younger in-flight instructions squashed after a redirect (range 1..7).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  exec result present this cycle
- wb_rd  in  5  destination register index
- wb_rd_we  in  1  result writes rd
- wb_rd_value  in  32  value for rd
- wb_redirect  in  1  jump or taken branch (exec jamp|branch)
- wb_next_pc  in  32  redirect target
- stall  in  1  fetch stall; freezes PC and flush counter
- rs1_addr  in  5  read port 1 index
- rs2_addr  in  5  read port 2 index
- rs1_data  out  32  read port 1 data
- rs2_data  out  32  read port 2 data
- pc_reg  out  32  current fetch PC
- flush  out  1  high while in FLUSH
- misaligned  out  1  sticky: redirect target bit1 was set
- instret  out  32  retired-instruction count

Behaviour:
- Reset: asynchronous on rst_n low.
  - All registers x0..x31 = 0; pc_reg = RESET_PC; state = RUN; flush = 0; misaligned = 0; instret = 0.
  - Reset mid-flush returns to RUN immediately, with no pending squash.
- Commit: an instruction commits in a cycle when state == RUN and wb_valid == 1. Its effects become visible at the next rising edge (1-cycle latency).
  - Register write: if wb_rd_we == 1 and wb_rd != 0, then regs[wb_rd] <= wb_rd_value.
  - Writes to x0 are discarded, and x0 always reads 0.
  - instret increments by 1 per commit and wraps modulo 2^32.
- PC:
  - Commit with wb_redirect == 1: pc_reg <= {wb_next_pc[31:1], 1'b0}, regardless of stall. If wb_next_pc[1] == 1, misaligned <= 1; it stays set until reset.
  - Otherwise, if stall == 0: pc_reg <= pc_reg + 4, wrapping 32'hFFFF_FFFC -> 0.
  - If stall == 1: pc_reg holds.
- FSM states RUN and FLUSH, with a 3-bit counter cnt:
  - RUN -> FLUSH on a committed redirect; cnt <= FLUSH_CYCLES - 1.
  - In FLUSH: flush = 1. wb_valid inputs are squashed: no register write, no instret increment, and a wb_redirect is ignored. The PC advances sequentially per the PC rules.
  - FLUSH with stall == 0: if cnt == 0, go to RUN; else cnt <= cnt - 1. With stall == 1, cnt holds.
  - Consequence: exactly FLUSH_CYCLES non-stalled cycles are squashed.
- Simultaneous events:
  - A committed write and a redirect in the same cycle both take effect (JAL/JALR link).
  - Stall never blocks a commit; it only freezes the PC increment and cnt.
- Reads: combinational. Address 0 returns 0. Without bypass, a read returns the pre-edge register value.

Optional Feature:
- Macro: WB_FORWARD_BYPASS_EN.
- Defined: if a committing write targets rsN_addr (nonzero) in the same cycle, rsN_data returns wb_rd_value (write-through bypass). Squashed writes are never bypassed.
- Undefined: reads return stored register contents only; exec must tolerate one cycle of staleness.

Decomposition:
- Shared package holds:
  - typedef wb_state_t {RUN, FLUSH}
  - typedef reg_idx_t logic[4:0]
  - typedef word_t logic[31:0]
  - constant PC_STEP = 32'h4
  - constant REG_ZERO = 5'd0
- One natural sub-module, regfile_2r1w: 32x32 storage, one write port, two combinational read ports, hardwired x0, and the optional bypass.
- The FSM, PC logic and counters stay in writeback_regfile.

Test Plan:
1. Reset with RESET_PC=32'h100, then 3 idle cycles with stall=0 -> pc_reg = 32'h10C, instret = 0, all reads 0.
2. Commit wb_rd=5, value 32'hDEADBEEF, then wb_rd=0, value 32'h1234 -> rs1_addr=5 reads DEADBEEF, rs1_addr=0 reads 0, instret = 2.
3. Redirect with wb_next_pc=32'h203 and wb_rd=1, value 32'h44 -> next cycle pc_reg = 32'h202, x1 = 44, misaligned = 1, flush = 1 for exactly 2 cycles. Valid writes to x2 during FLUSH are not committed and instret is not incremented.
4. Redirect during FLUSH to 32'h400 -> ignored; pc continues sequentially from the first target.
5. Assert rst_n low mid-FLUSH -> flush = 0, state RUN, pc = RESET_PC, misaligned = 0 immediately (asynchronous).
6. With WB_FORWARD_BYPASS_EN, same-cycle commit x7 = 32'h55 while rs2_addr=7 -> rs2_data = 32'h55 in that cycle. Without the macro, the old value is read and 32'h55 appears the next cycle.
